dmem_access_ctrl: RTL and testbench

- Memory-stage data-memory access controller. It sits directly upstream of the writeback control/select stage.
- Consumes the memory-stage decode fields dmem_sel, w_sel and r_sel (same encodings as the writeback control stage) plus the ALU address and store data.
- Runs a req/ack transaction to data memory, stalls the pipeline while busy, and returns the aligned, sign- or zero-extended load value for writeback.

---
 rtl/dmem_access_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: memory-stage data-memory access controller.
// Issues one req/ack transaction per load/store and stalls the pipeline
// while it is outstanding. Loads return an aligned, extended value.
// Stores drive lane-replicated data with byte enables.
// Optional build macro MISALIGN_TRAP_EN: traps misaligned half/word
// accesses. They go straight to DONE with no memory request and raise
// the misalign output. When the macro is undefined, misaligned accesses
// use the aligned lanes instead.
//
// Handshake: mem_req is held high in BUSY with stable address, data and
// enables. The access completes on the first cycle in which mem_ack=1.
// mem_ack outside BUSY is ignored.
module dmem_access_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid,
    input  logic              dmem_sel,
    input  logic [1:0]        w_sel,
    input  logic [2:0]        r_sel,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic              done,
    output logic [31:0]       rdata_out,
    output logic              bus_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
`ifdef MISALIGN_TRAP_EN
    output logic              misalign,
`endif
    output logic [1:0]        dbg_state
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [1:0] W_SB = 2'b00;
    localparam logic [1:0] W_SH = 2'b01;
    localparam logic [1:0] W_SW = 2'b10;

    localparam logic [2:0] R_LB  = 3'b000;
    localparam logic [2:0] R_LH  = 3'b010;
    localparam logic [2:0] R_LW  = 3'b011;
    localparam logic [2:0] R_LBU = 3'b100;
    localparam logic [2:0] R_LHU = 3'b101;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [1:0]        state_q, state_d;
    logic              is_store_q;
    logic [1:0]        w_sel_q;
    logic [2:0]        r_sel_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [31:0]       rdata_q;
    logic              bus_err_q;

    logic              is_store, is_load, start;
    logic              busy, timeout_hit, trap;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [31:0]       ld_ext;
    logic [3:0]        st_be;
    logic [31:0]       st_wdata;

    // Decode whether the presented instruction needs a memory access.
    always_comb begin
        is_store = dmem_sel & (w_sel != 2'b11);
        is_load  = ~dmem_sel & ((r_sel == R_LB) | (r_sel == R_LH) | (r_sel == R_LW) |
                                (r_sel == R_LBU) | (r_sel == R_LHU));
        start    = valid & (is_store | is_load);
    end

`ifdef MISALIGN_TRAP_EN
    logic misalign_q;
    logic half_acc, word_acc;

    // Half accesses need addr[0]=0 and word accesses need addr[1:0]=0.
    always_comb begin
        half_acc = is_store ? (w_sel == W_SH) : ((r_sel == R_LH) | (r_sel == R_LHU));
        word_acc = is_store ? (w_sel == W_SW) : (r_sel == R_LW);
        trap     = (half_acc & addr[0]) | (word_acc & (addr[1:0] != 2'b00));
    end

    assign misalign = misalign_q;
`else
    assign trap = 1'b0;
`endif

    // Timeout fires on the last allowed BUSY cycle. A zero TIMEOUT never fires.
    always_comb begin
        busy        = (state_q == BUSY);
        timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
    end

    // Next-state logic for the IDLE/BUSY/DONE sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = trap ? DONE : BUSY;
            BUSY:    if (mem_ack || timeout_hit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Select the addressed byte or half of the returned word and extend it.
    always_comb begin
        case (addr_q[1:0])
            2'd0:    lane_b = mem_rdata[7:0];
            2'd1:    lane_b = mem_rdata[15:8];
            2'd2:    lane_b = mem_rdata[23:16];
            default: lane_b = mem_rdata[31:24];
        endcase
        lane_h = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_sel_q)
            R_LB:    ld_ext = {{24{lane_b[7]}}, lane_b};
            R_LBU:   ld_ext = {24'h0, lane_b};
            R_LH:    ld_ext = {{16{lane_h[15]}}, lane_h};
            R_LHU:   ld_ext = {16'h0, lane_h};
            default: ld_ext = mem_rdata;
        endcase
    end

    // Compute store byte enables and lane-replicated write data from latched fields.
    always_comb begin
        case (w_sel_q)
            W_SB: begin
                st_be    = 4'b0001 << addr_q[1:0];
                st_wdata = {4{wdata_q[7:0]}};
            end
            W_SH: begin
                st_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = wdata_q;
            end
        endcase
    end

    // Drive the pipeline and memory outputs. Memory-side values are zero outside BUSY.
    always_comb begin
        stall     = ((state_q == IDLE) & start) | busy;
        done      = (state_q == DONE);
        bus_err   = bus_err_q;
        rdata_out = rdata_q;
        mem_req   = busy;
        mem_we    = busy & is_store_q;
        mem_be    = busy ? (is_store_q ? st_be : 4'b1111) : 4'b0000;
        mem_addr  = busy ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
        mem_wdata = (busy & is_store_q) ? st_wdata : 32'h0;
        dbg_state = state_q;
    end

    // Registered state: latch the operation on start and capture the result on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            is_store_q <= 1'b0;
            w_sel_q    <= 2'b00;
            r_sel_q    <= 3'b000;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            cnt_q      <= '0;
            rdata_q    <= 32'h0;
            bus_err_q  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        is_store_q <= is_store;
                        w_sel_q    <= w_sel;
                        r_sel_q    <= r_sel;
                        addr_q     <= addr;
                        wdata_q    <= wdata;
                        cnt_q      <= '0;
                        bus_err_q  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
                        if (trap) begin
                            misalign_q <= 1'b1;
                            rdata_q    <= 32'h0;
                        end
`endif
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        rdata_q <= is_store_q ? 32'h0 : ld_ext;
                    end else if (timeout_hit) begin
                        rdata_q   <= 32'h0;
                        bus_err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    bus_err_q <= 1'b0;
`ifdef MISALIGN_TRAP_EN
                    misalign_q <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: self-checking bench for dmem_access_ctrl.
// Expected results are queued when an access is driven. They are popped
// and compared when the DUT pulses done.
module tb_dmem_access_ctrl;

    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 16;

    localparam logic [1:0] W_SB = 2'b00, W_SH = 2'b01, W_SW = 2'b10, W_NONE = 2'b11;
    localparam logic [2:0] R_LB = 3'b000, R_LH = 3'b010, R_LW = 3'b011,
                           R_LBU = 3'b100, R_LHU = 3'b101, R_NONE = 3'b111;

    // Clock and reset.
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              valid, dmem_sel;
    logic [1:0]        w_sel;
    logic [2:0]        r_sel;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              stall, done, bus_err, mem_req, mem_we, mem_ack;
    logic [31:0]       rdata_out, mem_wdata, mem_rdata;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [1:0]        dbg_state;
`ifdef MISALIGN_TRAP_EN
    logic              misalign;
`endif

    int n_checks = 0;
    int n_errors = 0;
    // Entry: {check_rdata, bus_err, rdata}
    logic [33:0] exp_q[$];
    logic [33:0] mon_e;

    dmem_access_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid     (valid),
        .dmem_sel  (dmem_sel),
        .w_sel     (w_sel),
        .r_sel     (r_sel),
        .addr      (addr),
        .wdata     (wdata),
        .stall     (stall),
        .done      (done),
        .rdata_out (rdata_out),
        .bus_err   (bus_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
`ifdef MISALIGN_TRAP_EN
        .misalign  (misalign),
`endif
        .dbg_state (dbg_state)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: pop an expected result on every done pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    check_val("done_unexpected", {63'b0, done}, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_val("bus_err", {63'b0, bus_err}, {63'b0, mon_e[32]});
                    if (mon_e[33]) check_val("rdata_out", {32'b0, rdata_out}, {32'b0, mon_e[31:0]});
                end
            end else begin
                check_val("bus_err_not_done", {63'b0, bus_err}, 64'd0);
            end
        end
    end

    // Driver: one full access, starting #1 after a posedge with the DUT in IDLE.
    // ack_at < 0 means no ack, so the access runs into the timeout.
    task automatic run_access(input string tag, input logic st, input logic [1:0] ws,
                              input logic [2:0] rs, input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] mrd, input int ack_at,
                              input logic [3:0] exp_be, input logic [31:0] exp_wd,
                              input logic [31:0] exp_res, input logic exp_berr);
        int cyc;
        int exp_cyc;
        exp_cyc = (ack_at >= 0) ? ack_at + 1 : TIMEOUT;
        valid = 1'b1; dmem_sel = st; w_sel = ws; r_sel = rs; addr = a; wdata = wd;
        mem_rdata = mrd;
        @(negedge clk);
        check_val({tag, "_stall_idle"}, {63'b0, stall}, 64'd1);
        check_val({tag, "_req_idle"}, {63'b0, mem_req}, 64'd0);
        exp_q.push_back({~st, exp_berr, exp_res});
        @(posedge clk); #1;
        // Disturb the inputs. The DUT must work from its latched copy.
        addr = $urandom; wdata = $urandom;
        cyc = 0;
        while (!done && cyc < 64) begin
            mem_ack = (cyc == ack_at);
            @(negedge clk);
            check_val({tag, "_stall_busy"}, {63'b0, stall}, 64'd1);
            check_val({tag, "_req"}, {63'b0, mem_req}, 64'd1);
            check_val({tag, "_we"}, {63'b0, mem_we}, {63'b0, st});
            check_val({tag, "_be"}, {60'b0, mem_be}, {60'b0, exp_be});
            check_val({tag, "_addr"}, {32'b0, mem_addr}, {32'b0, a[31:2], 2'b00});
            if (st) check_val({tag, "_wdata"}, {32'b0, mem_wdata}, {32'b0, exp_wd});
            @(posedge clk); #1;
            mem_ack = 1'b0;
            cyc++;
        end
        check_val({tag, "_busy_cycles"}, cyc, exp_cyc);
        @(negedge clk);
        check_val({tag, "_done"}, {63'b0, done}, 64'd1);
        check_val({tag, "_stall_done"}, {63'b0, stall}, 64'd0);
        check_val({tag, "_req_done"}, {63'b0, mem_req}, 64'd0);
        @(posedge clk); #1;
        valid = 1'b0;
        @(negedge clk);
        check_val({tag, "_back_idle"}, {62'b0, dbg_state}, 64'd0);
        check_val({tag, "_no_restart"}, {63'b0, done}, 64'd0);
        @(posedge clk); #1;
    endtask

    // Driver: an instruction that must not start an access.
    task automatic run_noaccess(input string tag, input logic v, input logic st,
                                input logic [1:0] ws, input logic [2:0] rs);
        valid = v; dmem_sel = st; w_sel = ws; r_sel = rs; addr = 32'h4000;
        @(negedge clk);
        check_val({tag, "_stall"}, {63'b0, stall}, 64'd0);
        @(posedge clk); #1;
        valid = 1'b0;
        @(negedge clk);
        check_val({tag, "_idle"}, {62'b0, dbg_state}, 64'd0);
        check_val({tag, "_req"}, {63'b0, mem_req}, 64'd0);
        @(posedge clk); #1;
    endtask

    // Watchdog: stop the run if it stalls.
    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ra, rd;
        int          rk;
        valid = 0; dmem_sel = 0; w_sel = W_NONE; r_sel = R_NONE; addr = '0; wdata = '0;
        mem_rdata = '0; mem_ack = 0;
        #2;
        check_val("rst_stall", {63'b0, stall}, 64'd0);
        check_val("rst_done", {63'b0, done}, 64'd0);
        check_val("rst_req", {63'b0, mem_req}, 64'd0);
        check_val("rst_we", {63'b0, mem_we}, 64'd0);
        check_val("rst_be", {60'b0, mem_be}, 64'd0);
        check_val("rst_addr", {32'b0, mem_addr}, 64'd0);
        check_val("rst_wdata", {32'b0, mem_wdata}, 64'd0);
        check_val("rst_rdata", {32'b0, rdata_out}, 64'd0);
        check_val("rst_state", {62'b0, dbg_state}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Stores
        run_access("sw",   1, W_SW, R_NONE, 32'h1004, 32'hDEADBEEF, 32'h0, 0, 4'b1111, 32'hDEADBEEF, 32'h0, 0);
        run_access("sb3",  1, W_SB, R_NONE, 32'h2003, 32'h000000A5, 32'h0, 0, 4'b1000, 32'hA5A5A5A5, 32'h0, 0);
        run_access("sb1",  1, W_SB, R_NONE, 32'h2001, 32'h1234563C, 32'h0, 1, 4'b0010, 32'h3C3C3C3C, 32'h0, 0);
        run_access("sh2",  1, W_SH, R_NONE, 32'h2002, 32'h1234BEEF, 32'h0, 0, 4'b1100, 32'hBEEFBEEF, 32'h0, 0);
        run_access("sh0",  1, W_SH, R_NONE, 32'h2000, 32'h5555A0B1, 32'h0, 2, 4'b0011, 32'hA0B1A0B1, 32'h0, 0);

        // Loads from 0x80FF7F01
        run_access("lb3",  0, W_NONE, R_LB,  32'h3003, 32'h0, 32'h80FF7F01, 0, 4'b1111, 32'h0, 32'hFFFFFF80, 0);
        run_access("lbu3", 0, W_NONE, R_LBU, 32'h3003, 32'h0, 32'h80FF7F01, 0, 4'b1111, 32'h0, 32'h00000080, 0);
        run_access("lb2",  0, W_NONE, R_LB,  32'h3002, 32'h0, 32'h80FF7F01, 0, 4'b1111, 32'h0, 32'hFFFFFFFF, 0);
        run_access("lb1",  0, W_NONE, R_LB,  32'h3001, 32'h0, 32'h80FF7F01, 1, 4'b1111, 32'h0, 32'h0000007F, 0);
        run_access("lbu0", 0, W_NONE, R_LBU, 32'h3000, 32'h0, 32'h80FF7F01, 0, 4'b1111, 32'h0, 32'h00000001, 0);
        run_access("lh2",  0, W_NONE, R_LH,  32'h3002, 32'h0, 32'h80FF7F01, 0, 4'b1111, 32'h0, 32'hFFFF80FF, 0);
        run_access("lhu0", 0, W_NONE, R_LHU, 32'h3000, 32'h0, 32'h80FF7F01, 0, 4'b1111, 32'h0, 32'h00007F01, 0);
        run_access("lhu2", 0, W_NONE, R_LHU, 32'h3002, 32'h0, 32'h80FF7F01, 0, 4'b1111, 32'h0, 32'h000080FF, 0);
        run_access("lh0",  0, W_NONE, R_LH,  32'h3000, 32'h0, 32'h80FF7F01, 0, 4'b1111, 32'h0, 32'h00007F01, 0);
        run_access("lw",   0, W_NONE, R_LW,  32'h3000, 32'h0, 32'h80FF7F01, 3, 4'b1111, 32'h0, 32'h80FF7F01, 0);

        // Timeout and the ack-versus-timeout race on the last cycle
        run_access("lw_tmo", 0, W_NONE, R_LW, 32'h5008, 32'h0, 32'h12345678, -1, 4'b1111, 32'h0, 32'h0, 1);
        run_access("lw_ack_last", 0, W_NONE, R_LW, 32'h500C, 32'h0, 32'hCAFEF00D, TIMEOUT - 1, 4'b1111, 32'h0, 32'hCAFEF00D, 0);
        run_access("lw_after_tmo", 0, W_NONE, R_LW, 32'h5010, 32'h0, 32'h0BADC0DE, 0, 4'b1111, 32'h0, 32'h0BADC0DE, 0);

        // Instructions that must not access memory
        run_noaccess("no_valid", 0, 0, W_NONE, R_LW);
        run_noaccess("r_none",   1, 0, W_SW,   R_NONE);
        run_noaccess("r_001",    1, 0, W_SW,   3'b001);
        run_noaccess("r_110",    1, 0, W_SW,   3'b110);
        run_noaccess("w_none",   1, 1, W_NONE, R_LW);

        // Misaligned accesses
`ifdef MISALIGN_TRAP_EN
        valid = 1; dmem_sel = 0; w_sel = W_NONE; r_sel = R_LW; addr = 32'h1002;
        mem_rdata = 32'h11112222;
        @(negedge clk);
        check_val("mis_stall", {63'b0, stall}, 64'd1);
        exp_q.push_back({1'b1, 1'b0, 32'h0});
        @(posedge clk); #1;
        @(negedge clk);
        check_val("mis_done", {63'b0, done}, 64'd1);
        check_val("mis_flag", {63'b0, misalign}, 64'd1);
        check_val("mis_req", {63'b0, mem_req}, 64'd0);
        check_val("mis_we", {63'b0, mem_we}, 64'd0);
        @(posedge clk); #1;
        valid = 0;
        @(negedge clk);
        check_val("mis_flag_clr", {63'b0, misalign}, 64'd0);
        check_val("mis_idle", {62'b0, dbg_state}, 64'd0);
        @(posedge clk); #1;
`else
        run_access("lw_mis", 0, W_NONE, R_LW, 32'h1002, 32'h0, 32'h11112222, 0, 4'b1111, 32'h0, 32'h11112222, 0);
        run_access("lh_mis", 0, W_NONE, R_LH, 32'h3003, 32'h0, 32'h80FF7F01, 0, 4'b1111, 32'h0, 32'hFFFF80FF, 0);
        run_access("sh_mis", 1, W_SH, R_NONE, 32'h2001, 32'h0000ABCD, 32'h0, 0, 4'b0011, 32'hABCDABCD, 32'h0, 0);
`endif

        // Reset while BUSY drops the request at once
        valid = 1; dmem_sel = 0; w_sel = W_NONE; r_sel = R_LW; addr = 32'h6000;
        @(posedge clk); #1;
        @(negedge clk);
        check_val("rstb_req_before", {63'b0, mem_req}, 64'd1);
        #2;
        rst_n = 1'b0; valid = 1'b0;
        #1;
        check_val("rstb_req", {63'b0, mem_req}, 64'd0);
        check_val("rstb_stall", {63'b0, stall}, 64'd0);
        check_val("rstb_state", {62'b0, dbg_state}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_access("lw_post_rst", 0, W_NONE, R_LW, 32'h6004, 32'h0, 32'h13579BDF, 1, 4'b1111, 32'h0, 32'h13579BDF, 0);

        // Random word loads with random ack latency
        for (int i = 0; i < 6; i++) begin
            ra = $urandom_range(0, 32'hFFFF) & 32'hFFFF_FFFC;
            rd = $urandom;
            rk = $urandom_range(0, 5);
            run_access("lw_rand", 0, W_NONE, R_LW, ra, 32'h0, rd, rk, 4'b1111, 32'h0, rd, 0);
        end

        repeat (2) @(posedge clk);
        check_val("exp_q_empty", exp_q.size(), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
